// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared types and constants for the PIO input capture block
// Contents:
//   pio_cfg_sel_e    : config write target select
//   PIO_SYNC_STAGES  : depth of the pad synchronizer
//   PIO_PRIME_CYCLES : cycles after reset during which edges are suppressed
package pio_pkg;

    typedef enum logic [1:0] {
        PIO_SEL_RISE_IE  = 2'd0,
        PIO_SEL_FALL_IE  = 2'd1,
        PIO_SEL_RISE_CLR = 2'd2,
        PIO_SEL_FALL_CLR = 2'd3
    } pio_cfg_sel_e;

    localparam int PIO_SYNC_STAGES  = 2;
    localparam int PIO_PRIME_CYCLES = 2;

endpackage

// File: rtl/pio_in_capture_if.sv
// rtl/pio_in_capture_if.sv - register write bus for the PIO input capture block
// Signals:
//   cfg_we      : one-cycle write strobe
//   cfg_sel     : write target (pio_cfg_sel_e encoding)
//   cfg_wdata   : write data
//   cfg_wenable : per-bit write enable
// Modports: master drives the bus, slave (the capture block) receives it.
interface pio_in_capture_if #(
    parameter int dataWidth = 32
);

    logic                 cfg_we;
    logic [1:0]           cfg_sel;
    logic [dataWidth-1:0] cfg_wdata;
    logic [dataWidth-1:0] cfg_wenable;

    modport master (
        output cfg_we,
        output cfg_sel,
        output cfg_wdata,
        output cfg_wenable
    );

    modport slave (
        input cfg_we,
        input cfg_sel,
        input cfg_wdata,
        input cfg_wenable
    );

endinterface

// File: rtl/pio_in_bit.sv
// rtl/pio_in_bit.sv - per-bit synchronizer, optional debounce and edge detect
// Optional feature: PIO_IN_DEBOUNCE_EN adds a per-bit stability counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   pad_in      : raw asynchronous pad level
//   prime       : shared flag, high for the first cycles after reset
//   lvl         : accepted level
//   rise_pulse  : accepted level is going 0->1 on the next edge
//   fall_pulse  : accepted level is going 1->0 on the next edge
module pio_in_bit
    import pio_pkg::*;
`ifdef PIO_IN_DEBOUNCE_EN
#(
    parameter int debounceCycles = 4
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic pad_in,
    input  logic prime,
    output logic lvl,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [PIO_SYNC_STAGES-1:0] sync_q;
    logic [PIO_SYNC_STAGES-1:0] sync_d;
    logic                       lvl_q;
    logic                       lvl_d;
    logic                       s2;
    logic                       s2_next;

    assign s2      = sync_q[PIO_SYNC_STAGES-1];
    // Value s2 takes on the coming edge. Loading lvl from it during prime
    // makes lvl equal s2 the moment prime ends, so a pad already high at
    // reset release never appears as a rise.
    assign s2_next = sync_q[PIO_SYNC_STAGES-2];

    always_comb begin
        sync_d = {sync_q[PIO_SYNC_STAGES-2:0], pad_in};
    end

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(debounceCycles + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(debounceCycles - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter runs only while s2 disagrees with lvl; any agreement
    // restarts it, so only an unbroken run of debounceCycles is accepted.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (prime) begin
            lvl_d = s2_next;
        end else if (s2 != lvl_q) begin
            if (cnt_q == CNT_LAST) begin
                lvl_d = s2;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        lvl_d = prime ? s2_next : s2;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            lvl_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            lvl_q  <= lvl_d;
        end
    end

    assign lvl        = lvl_q;
    assign rise_pulse = ~prime & ~lvl_q &  lvl_d;
    assign fall_pulse = ~prime &  lvl_q & ~lvl_d;

endmodule

// File: rtl/pio_in_capture.sv
// rtl/pio_in_capture.sv - PIO pad input capture with edge-pending interrupts
// Optional feature: PIO_IN_DEBOUNCE_EN enables per-bit debounce of debounceCycles.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   pad_in               : raw pad levels, asynchronous to clk
//   cfg                  : register write bus (pio_in_capture_if.slave)
//   in_rdata             : accepted input levels
//   rise_ie, fall_ie     : interrupt enables
//   rise_pend, fall_pend : sticky edge-pending bits, write-1-to-clear
//   irq0, irq1           : registered OR of enabled rise / fall pending bits
module pio_in_capture
    import pio_pkg::*;
#(
    parameter int dataWidth      = 32,
    parameter int debounceCycles = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [dataWidth-1:0] pad_in,
    pio_in_capture_if.slave      cfg,
    output logic [dataWidth-1:0] in_rdata,
    output logic [dataWidth-1:0] rise_ie,
    output logic [dataWidth-1:0] fall_ie,
    output logic [dataWidth-1:0] rise_pend,
    output logic [dataWidth-1:0] fall_pend,
    output logic                 irq0,
    output logic                 irq1
);

    if (debounceCycles < 1 || debounceCycles > 255) begin : g_bad_debounce
        $error("debounceCycles must be within 1..255");
    end

    logic [1:0]           prime_cnt_q;
    logic [1:0]           prime_cnt_d;
    logic                 prime;

    logic [dataWidth-1:0] rise_pulse;
    logic [dataWidth-1:0] fall_pulse;

    logic [dataWidth-1:0] rise_ie_q;
    logic [dataWidth-1:0] rise_ie_d;
    logic [dataWidth-1:0] fall_ie_q;
    logic [dataWidth-1:0] fall_ie_d;
    logic [dataWidth-1:0] rise_pend_q;
    logic [dataWidth-1:0] rise_pend_d;
    logic [dataWidth-1:0] fall_pend_q;
    logic [dataWidth-1:0] fall_pend_d;
    logic [dataWidth-1:0] rise_clr;
    logic [dataWidth-1:0] fall_clr;
    logic                 irq0_q;
    logic                 irq0_d;
    logic                 irq1_q;
    logic                 irq1_d;

    // Prime counter saturates at PIO_PRIME_CYCLES.
    assign prime = (prime_cnt_q < 2'(PIO_PRIME_CYCLES));

    always_comb begin
        prime_cnt_d = prime ? prime_cnt_q + 2'd1 : prime_cnt_q;
    end

    for (genvar i = 0; i < dataWidth; i++) begin : g_bit
        pio_in_bit
`ifdef PIO_IN_DEBOUNCE_EN
            #(.debounceCycles(debounceCycles))
`endif
        u_bit (
            .clk        (clk),
            .rst_n      (rst_n),
            .pad_in     (pad_in[i]),
            .prime      (prime),
            .lvl        (in_rdata[i]),
            .rise_pulse (rise_pulse[i]),
            .fall_pulse (fall_pulse[i])
        );
    end

    always_comb begin
        rise_ie_d = rise_ie_q;
        fall_ie_d = fall_ie_q;
        rise_clr  = '0;
        fall_clr  = '0;
        if (cfg.cfg_we) begin
            case (pio_cfg_sel_e'(cfg.cfg_sel))
                PIO_SEL_RISE_IE:
                    rise_ie_d = (cfg.cfg_wenable & cfg.cfg_wdata) | (~cfg.cfg_wenable & rise_ie_q);
                PIO_SEL_FALL_IE:
                    fall_ie_d = (cfg.cfg_wenable & cfg.cfg_wdata) | (~cfg.cfg_wenable & fall_ie_q);
                PIO_SEL_RISE_CLR:
                    rise_clr = cfg.cfg_wenable & cfg.cfg_wdata;
                PIO_SEL_FALL_CLR:
                    fall_clr = cfg.cfg_wenable & cfg.cfg_wdata;
                default: ;
            endcase
        end
        // A new edge is OR-ed in after the clear so it is never lost.
        rise_pend_d = (rise_pend_q & ~rise_clr) | rise_pulse;
        fall_pend_d = (fall_pend_q & ~fall_clr) | fall_pulse;
        irq0_d      = |(rise_pend_q & rise_ie_q);
        irq1_d      = |(fall_pend_q & fall_ie_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt_q <= '0;
            rise_ie_q   <= '0;
            fall_ie_q   <= '0;
            rise_pend_q <= '0;
            fall_pend_q <= '0;
            irq0_q      <= 1'b0;
            irq1_q      <= 1'b0;
        end else begin
            prime_cnt_q <= prime_cnt_d;
            rise_ie_q   <= rise_ie_d;
            fall_ie_q   <= fall_ie_d;
            rise_pend_q <= rise_pend_d;
            fall_pend_q <= fall_pend_d;
            irq0_q      <= irq0_d;
            irq1_q      <= irq1_d;
        end
    end

    assign rise_ie   = rise_ie_q;
    assign fall_ie   = fall_ie_q;
    assign rise_pend = rise_pend_q;
    assign fall_pend = fall_pend_q;
    assign irq0      = irq0_q;
    assign irq1      = irq1_q;

endmodule
